// File: rtl/ps2_key_receiver_pkg.sv
// Shared PS/2 receiver definitions: prefix bytes, FSM states, arrow scancodes
// and the frame parity helper.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    localparam logic [7:0] PS2_KEY_UP    = 8'h75;
    localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;
    localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Bundle of raw PS/2 lines plus the byte and key-event outputs of the receiver.
interface ps2_key_receiver_if;
    import ps2_pkg::*;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_brk;
    logic       key_valid;

    modport master (
        output ps2_clk, ps2_data,
        input  rx_byte, rx_valid, rx_err, key_code, key_ext, key_brk, key_valid
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output rx_byte, rx_valid, rx_err, key_code, key_ext, key_brk, key_valid
    );

endinterface

// File: rtl/ps2_key_receiver_line_filter.sv
// Two-flop synchronizer followed by a saturating glitch filter for one PS/2 line.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic       sync1_r;
    logic       sync2_r;
    logic       filt_r;
    logic [3:0] cnt_r;

    // Filtered value flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            filt_r  <= 1'b1;
            cnt_r   <= 4'd0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r != filt_r) begin
                if (cnt_r == CNT_LAST) begin
                    filt_r <= sync2_r;
                    cnt_r  <= 4'd0;
                end else begin
                    cnt_r <= cnt_r + 4'd1;
                end
            end else begin
                cnt_r <= 4'd0;
            end
        end
    end

    assign filt = filt_r;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host frame receiver with timeout and E0/F0 prefix stripping;
// emits one key event per make or break.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 56750
) (
    input  logic              clk,
    input  logic              reset,
    ps2_key_receiver_if.slave bus
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic       fclk_s;
    logic       fdata_s;
    logic       strike_s;
    logic       fclk_prev_r;
    ps2_state_e state_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       par_r;
    logic [15:0] tmo_r;
    logic [7:0] rx_byte_r;
    logic       rx_valid_r;
    logic       rx_err_r;
    logic       ext_pend_r;
    logic       brk_pend_r;
    logic [7:0] key_code_r;
    logic       key_ext_r;
    logic       key_brk_r;
    logic       key_valid_r;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.ps2_clk),
        .filt  (fclk_s)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.ps2_data),
        .filt  (fdata_s)
    );

    assign strike_s = fclk_prev_r & ~fclk_s;

    // Frame FSM with inter-strike timeout; a strike always beats the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fclk_prev_r <= 1'b1;
            state_r     <= IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            par_r       <= 1'b0;
            tmo_r       <= 16'd0;
            rx_byte_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            rx_err_r    <= 1'b0;
        end else begin
            fclk_prev_r <= fclk_s;
            rx_valid_r  <= 1'b0;
            rx_err_r    <= 1'b0;
            if (strike_s) begin
                tmo_r <= 16'd0;
                case (state_r)
                    IDLE: begin
                        if (!fdata_s) begin
                            state_r   <= DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    DATA: begin
                        shift_r[bit_cnt_r] <= fdata_s;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= PARITY;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                    PARITY: begin
                        par_r   <= fdata_s;
                        state_r <= STOP;
                    end
                    STOP: begin
                        state_r <= IDLE;
                        if (fdata_s && odd_parity_ok(shift_r, par_r)) begin
                            rx_byte_r  <= shift_r;
                            rx_valid_r <= 1'b1;
                        end else begin
                            rx_err_r <= 1'b1;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end else if (state_r == IDLE) begin
                tmo_r <= 16'd0;
            end else if (tmo_r == TMO_LAST) begin
                state_r  <= IDLE;
                tmo_r    <= 16'd0;
                rx_err_r <= 1'b1;
            end else begin
                tmo_r <= tmo_r + 16'd1;
            end
        end
    end

    // Prefix decoder: E0/F0 only arm pending flags, any other byte is a key event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_pend_r  <= 1'b0;
            brk_pend_r  <= 1'b0;
            key_code_r  <= 8'h00;
            key_ext_r   <= 1'b0;
            key_brk_r   <= 1'b0;
            key_valid_r <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            if (rx_err_r) begin
                ext_pend_r <= 1'b0;
                brk_pend_r <= 1'b0;
            end else if (rx_valid_r) begin
                case (rx_byte_r)
                    PS2_PFX_EXT: ext_pend_r <= 1'b1;
                    PS2_PFX_BRK: brk_pend_r <= 1'b1;
                    default: begin
                        key_code_r  <= rx_byte_r;
                        key_ext_r   <= ext_pend_r;
                        key_brk_r   <= brk_pend_r;
                        key_valid_r <= 1'b1;
                        ext_pend_r  <= 1'b0;
                        brk_pend_r  <= 1'b0;
                    end
                endcase
            end else begin
                ext_pend_r <= ext_pend_r;
                brk_pend_r <= brk_pend_r;
            end
        end
    end

    assign bus.rx_byte   = rx_byte_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.rx_err    = rx_err_r;
    assign bus.key_code  = key_code_r;
    assign bus.key_ext   = key_ext_r;
    assign bus.key_brk   = key_brk_r;
    assign bus.key_valid = key_valid_r;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_key_receiver;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TMO  = 300;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_key_receiver_if bus();

    ps2_key_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_rxv = 0;
    int n_rxe = 0;
    int n_key = 0;
    int n_both = 0;
    int last_fall = 0;
    int rv0, re0, k0;

    // Free-running cycle count used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.rx_valid) n_rxv <= n_rxv + 1;
        if (bus.rx_err) n_rxe <= n_rxe + 1;
        if (bus.key_valid) n_key <= n_key + 1;
        if (bus.rx_valid && bus.rx_err) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        rv0 = n_rxv;
        re0 = n_rxe;
        k0  = n_key;
    endtask

    // Drives the first n_edges bits of a frame; optional short low glitch during bit 4.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_val,
                              input int n_edges, input logic glitch);
        logic [10:0] bits;
        bits = {stop_val, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < n_edges; i++) begin
            @(negedge clk);
            bus.ps2_data = bits[i];
            if (glitch && i == 4) begin
                idle(10);
                bus.ps2_clk = 1'b0;
                idle(FL - 1);
                bus.ps2_clk = 1'b1;
                idle(HALF - 10 - (FL - 1));
            end else begin
                idle(HALF);
            end
            bus.ps2_clk = 1'b0;
            last_fall = cyc;
            idle(HALF);
            bus.ps2_clk = 1'b1;
        end
        @(negedge clk);
        bus.ps2_data = 1'b1;
        idle(HALF);
    endtask

    task automatic frame(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rx_byte"}, 32'(bus.rx_byte), 32'h0);
        chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'h0);
        chk({tag, "_rx_err"}, 32'(bus.rx_err), 32'h0);
        chk({tag, "_key_code"}, 32'(bus.key_code), 32'h0);
        chk({tag, "_key_ext"}, 32'(bus.key_ext), 32'h0);
        chk({tag, "_key_brk"}, 32'(bus.key_brk), 32'h0);
        chk({tag, "_key_valid"}, 32'(bus.key_valid), 32'h0);
    endtask

    initial begin
        int seen;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b1;
        idle(3);
        chk_outputs_zero("rst");
        reset = 1'b0;
        idle(5);

        // Plain make code
        snap();
        frame(8'h1C);
        chk("t1_rxv", 32'(n_rxv - rv0), 32'd1);
        chk("t1_byte", 32'(bus.rx_byte), 32'h1C);
        chk("t1_keyv", 32'(n_key - k0), 32'd1);
        chk("t1_code", 32'(bus.key_code), 32'h1C);
        chk("t1_ext", 32'(bus.key_ext), 32'h0);
        chk("t1_brk", 32'(bus.key_brk), 32'h0);
        chk("t1_err", 32'(n_rxe - re0), 32'd0);

        // Extended break, then a plain make
        snap();
        frame(8'hE0);
        frame(8'hF0);
        chk("t2_nokey", 32'(n_key - k0), 32'd0);
        frame(8'h75);
        chk("t2_rxv", 32'(n_rxv - rv0), 32'd3);
        chk("t2_keyv", 32'(n_key - k0), 32'd1);
        chk("t2_code", 32'(bus.key_code), 32'h75);
        chk("t2_ext", 32'(bus.key_ext), 32'h1);
        chk("t2_brk", 32'(bus.key_brk), 32'h1);
        frame(8'h6B);
        chk("t2b_code", 32'(bus.key_code), 32'h6B);
        chk("t2b_ext", 32'(bus.key_ext), 32'h0);
        chk("t2b_brk", 32'(bus.key_brk), 32'h0);

        // Parity error, recovery, stop error
        snap();
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        chk("t3_err", 32'(n_rxe - re0), 32'd1);
        chk("t3_norxv", 32'(n_rxv - rv0), 32'd0);
        chk("t3_hold", 32'(bus.rx_byte), 32'h6B);
        frame(8'h1C);
        chk("t3_rxv", 32'(n_rxv - rv0), 32'd1);
        chk("t3_byte", 32'(bus.rx_byte), 32'h1C);
        snap();
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        chk("t3_stop_err", 32'(n_rxe - re0), 32'd1);
        chk("t3_stop_norxv", 32'(n_rxv - rv0), 32'd0);

        // Timeout after five data bits
        snap();
        send_frame(8'h29, 1'b0, 1'b1, 6, 1'b0);
        seen = -1;
        for (int k = 0; k < TMO + 200 && seen < 0; k++) begin
            @(negedge clk);
            if (bus.rx_err) seen = cyc - last_fall;
        end
        chk("t4_tmo_lat", 32'(seen), 32'(3 + FL + TMO));
        idle(5);
        frame(8'h29);
        chk("t4_err", 32'(n_rxe - re0), 32'd1);
        chk("t4_rxv", 32'(n_rxv - rv0), 32'd1);
        chk("t4_byte", 32'(bus.rx_byte), 32'h29);
        chk("t4_code", 32'(bus.key_code), 32'h29);

        // Sub-filter glitch on ps2_clk
        snap();
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b1);
        chk("t5_rxv", 32'(n_rxv - rv0), 32'd1);
        chk("t5_byte", 32'(bus.rx_byte), 32'h5A);
        chk("t5_err", 32'(n_rxe - re0), 32'd0);

        // Error discards pending break prefix
        snap();
        frame(8'hF0);
        send_frame(8'h33, 1'b1, 1'b1, 11, 1'b0);
        frame(8'h74);
        chk("t5b_keyv", 32'(n_key - k0), 32'd1);
        chk("t5b_code", 32'(bus.key_code), 32'h74);
        chk("t5b_brk", 32'(bus.key_brk), 32'h0);
        chk("t5b_err", 32'(n_rxe - re0), 32'd1);

        // 0xE1 is an ordinary byte
        snap();
        frame(8'hE1);
        chk("e1_keyv", 32'(n_key - k0), 32'd1);
        chk("e1_code", 32'(bus.key_code), 32'hE1);

        // Reset mid-frame with an extended prefix pending
        frame(8'hE0);
        snap();
        send_frame(8'h72, 1'b0, 1'b1, 4, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_outputs_zero("t6");
        idle(3);
        reset = 1'b0;
        idle(5);
        chk("t6_noerr", 32'(n_rxe - re0), 32'd0);
        frame(8'h72);
        chk("t6_code", 32'(bus.key_code), 32'h72);
        chk("t6_ext", 32'(bus.key_ext), 32'h0);
        chk("t6_brk", 32'(bus.key_brk), 32'h0);

        chk("exclusive", 32'(n_both), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
